// File: rtl/adder_subtractor_seq_nbits.sv
`default_nettype none
// ============================================================================
//  Module   : adder_subtractor_seq_nbits
//  Purpose  : Multi-cycle WIDTH-bit adder/subtractor. Adds or subtracts
//             CHUNK bits per clock, LSB chunk first, and keeps the carry
//             between chunks in a register. Uses a start/busy/done
//             handshake, and the result is held until the next accepted
//             start.
//  Ports    : clk    - clock, all logic on the rising edge
//             rst_n  - synchronous reset, active low
//             start  - request, sampled only in IDLE or DONE
//             a, b   - operands, latched on an accepted start
//             k      - mode, 0 = add and 1 = subtract, latched on accept
//             busy   - high while the chunks are being processed
//             done   - one-cycle pulse, sum/cout valid
//             sum    - result, modulo 2^WIDTH
//             cout   - carry out of the MSB (for subtract: 1 = no borrow)
//             ovf    - signed overflow, only when ADDSUB_OVERFLOW_EN is
//                      defined
//  Config   : `define ADDSUB_OVERFLOW_EN adds the ovf output and its logic.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_subtractor_seq_nbits #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             k,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDSUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NCHUNK - 1);

  // Catch an operand width that does not split into whole chunks.
  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_chunk_check
    $error("adder_subtractor_seq_nbits: CHUNK (%0d) must divide WIDTH (%0d)",
           CHUNK, WIDTH);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;        // already inverted when subtracting
  logic [WIDTH-1:0] sum_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic             cout_q;
  logic             done_q;

  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic [CHUNK:0]   w_chunk_sum;
  logic             w_accept;
  logic             w_last;

  assign w_chunk_a   = a_q[idx_q*CHUNK +: CHUNK];
  assign w_chunk_b   = b_q[idx_q*CHUNK +: CHUNK];
  assign w_chunk_sum = {1'b0, w_chunk_a} + {1'b0, w_chunk_b}
                     + {{CHUNK{1'b0}}, carry_q};

  assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_last   = (state_q == S_RUN) && (idx_q == C_LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the final chunk raises it.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            // Subtraction as a + ~b + 1: invert B and seed the carry with k.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{k}};
            carry_q <= k;
            sum_q   <= '0;
            idx_q   <= '0;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
          carry_q <= w_chunk_sum[CHUNK];
          idx_q   <= idx_q + IDXW'(1);
          if (w_last) begin
            cout_q  <= w_chunk_sum[CHUNK];
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef ADDSUB_OVERFLOW_EN
  logic ovf_q;
  logic w_msb_cin;

  // Carry into the MSB, recovered from the MSB sum bit of the final chunk.
  assign w_msb_cin = w_chunk_a[CHUNK-1] ^ w_chunk_b[CHUNK-1]
                   ^ w_chunk_sum[CHUNK-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (w_accept) begin
      ovf_q <= 1'b0;
    end else if (w_last) begin
      ovf_q <= w_msb_cin ^ w_chunk_sum[CHUNK];
    end
  end

  assign ovf = ovf_q;
`else
  // No signed-overflow flag in this build.
`endif

endmodule
`default_nettype wire
